stopwatch_bcd: RTL

- Downstream consumer of the clock divider's slow output.
- Samples the divider's `clk_out` as a plain data input in the `clk_in` domain and detects its rising edges. It never uses that signal as a clock.
- Counts whole seconds into a four-digit BCD MM:SS stopwatch with start/stop and clear control.
- Drives the display/decoder stage that follows.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/bcd_digit_counter.sv | 31 +++
 rtl/stopwatch_bcd.sv | 113 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM state encoding and BCD digit limits for the MM:SS stopwatch
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single BCD digit, wraps to 0 after MAX and flags carry to the next digit
module bcd_digit_counter #(
  parameter int MAX = 9
) (
  input  logic       clk_in,
  input  logic       Reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  assign carry = inc & (digit_q == 4'(MAX));

  always_comb begin
    digit_d = digit_q;
    if (clr || carry) digit_d = 4'd0;
    else if (inc)     digit_d = digit_q + 4'd1;
  end

  always_ff @(posedge clk_in) begin
    if (Reset) digit_q <= 4'd0;
    else       digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS BCD stopwatch counting rising edges of tick_src; optional lap freeze via STOPWATCH_LAP_EN
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRE_W         = 16
) (
  input  logic       clk_in,
  input  logic       Reset,
  input  logic       tick_src,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_hold,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  logic             s0_q, s1_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             rollover_q;
  logic             counting, sec_tick, digit_clr;
  logic             c0, c1, c2, c3;
  logic [3:0]       so, st, mo, mt;

  assign rise      = s0_q & ~s1_q;
  // A rise is judged against the state before any same-cycle command; clear discards it.
  assign counting  = (state_q == ST_RUN) & rise & ~clear;
  assign sec_tick  = counting & (pre_q == PRE_LAST);
  assign digit_clr = clear | (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (start_stop) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pre_d = pre_q;
    if (digit_clr)     pre_d = '0;
    else if (counting) pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (Reset) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      rollover_q <= 1'b0;
    end else begin
      s0_q       <= tick_src;
      s1_q       <= s0_q;
      state_q    <= state_d;
      pre_q      <= pre_d;
      rollover_q <= c3;
    end
  end

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk_in(clk_in), .Reset(Reset), .clr(digit_clr), .inc(sec_tick), .digit(so), .carry(c0));
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_in(clk_in), .Reset(Reset), .clr(digit_clr), .inc(c0), .digit(st), .carry(c1));
  bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk_in(clk_in), .Reset(Reset), .clr(digit_clr), .inc(c1), .digit(mo), .carry(c2));
  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk_in(clk_in), .Reset(Reset), .clr(digit_clr), .inc(c2), .digit(mt), .carry(c3));

  assign running  = (state_q == ST_RUN);
  assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_hold_q;
  logic [15:0] frozen_q;

  // Frozen copy is taken from the live registers, so counting carries on underneath.
  always_ff @(posedge clk_in) begin
    if (Reset) begin
      lap_hold_q <= 1'b0;
      frozen_q   <= '0;
    end else if (clear) begin
      lap_hold_q <= 1'b0;
    end else if (lap && (state_q == ST_RUN)) begin
      lap_hold_q <= ~lap_hold_q;
      if (!lap_hold_q) frozen_q <= {mt, mo, st, so};
    end
  end

  assign lap_hold = lap_hold_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} = lap_hold_q ? frozen_q : {mt, mo, st, so};
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt, mo, st, so};
`endif

endmodule
